router_sync: RTL and testbench
==============================

Name: router_sync

Overview:
Synchronizer and control block of the 1x3 packet router. It latches the 2-bit destination address at packet header time and decodes it into one-hot FIFO write enables. It muxes the addressed FIFO's full flag back to the router FSM. It generates per-FIFO valid-out flags and a soft-reset pulse for any output FIFO left unread for too long. It sits between the router FSM/register block and the three output FIFOs.

Parameters:
TIMEOUT, 30, consecutive cycles of vld_out_x high with read_enb_x low before soft_reset_x pulses (counter width 5 bits; supports 2..31).

Ports:
clock  input  1  system clock, all state updates on rising edge
resetn  input  1  synchronous active-low reset
detect_add  input  1  header detected; capture data_in as destination address
data_in  input  2  destination address (00→FIFO0, 01→FIFO1, 10→FIFO2, 11 invalid)
write_enb_reg  input  1  FSM request to write the current byte
read_enb_0/1/2  input  1 each  read strobe from each output port
empty_0/1/2  input  1 each  FIFO empty flags
full_0/1/2  input  1 each  FIFO full flags
vld_out_0/1/2  output  1 each  FIFO has data
write_enb  output  3  one-hot FIFO write enable
fifo_full  output  1  full flag of the addressed FIFO
soft_reset_0/1/2  output  1 each  one-cycle timeout pulse to the FIFO

Behaviour:
- Declaration order, fixed for positional instantiation: detect_add, data_in, write_enb_reg, clock, resetn, read_enb_0..2, empty_0..2, full_0..2, vld_out_0..2, write_enb, fifo_full, soft_reset_0..2.
- One clock; reset is synchronous and active-low (clock, resetn).
- Address register addr[1:0]:
  - Reset to 2'b00.
  - On a rising edge with detect_add=1, addr<=data_in; otherwise it holds.
  - Capture is visible one cycle after detect_add.
- write_enb (combinational from addr and write_enb_reg):
  - write_enb_reg=0 → 3'b000.
  - Otherwise addr 00→001, 01→010, 10→100, 11→000.
- fifo_full (combinational): addr 00→full_0, 01→full_1, 10→full_2, 11→0.
- vld_out_x = ~empty_x, combinational, independent of reset.
- Per-FIFO timeout counter cnt_x (5 bits) and registered soft_reset_x:
  - On reset: cnt_x=0, soft_reset_x=0.
  - If vld_out_x=0: cnt_x<=0, soft_reset_x<=0.
  - If vld_out_x=1 and read_enb_x=1: cnt_x<=0, soft_reset_x<=0.
  - If vld_out_x=1 and read_enb_x=0:
    - When cnt_x==TIMEOUT-1: soft_reset_x<=1 and cnt_x<=0.
    - Otherwise cnt_x<=cnt_x+1 and soft_reset_x<=0.
  - Net effect: soft_reset_x is a single-cycle pulse on the TIMEOUT-th consecutive idle edge, repeating every TIMEOUT cycles while the idle condition persists.
- The three counters are fully independent.
- Reset asserted mid-count clears the counter and the pulse on that edge.
- detect_add together with write_enb_reg in the same cycle: write_enb uses the old addr during that cycle and the new addr from the next cycle.

Test Plan:
- Reset, then detect_add=1, data_in=01, write_enb_reg=1 → after the next edge write_enb=3'b010; with full_1=1 (full_0=full_2=0), fifo_full=1.
- empty_0=1, empty_1=1, empty_2=0 → vld_out_0=0, vld_out_1=0, vld_out_2=1 immediately, including during reset.
- vld_out_2=1 and read_enb_2=0 held → soft_reset_2=1 for exactly one cycle on the 30th edge after reset release; pulses again 30 cycles later; soft_reset_0 and soft_reset_1 stay 0.
- Idle FIFO1 with read_enb_1 asserted on cycle 20 → counter cleared, no pulse until 30 further idle cycles.
- data_in=11 latched, write_enb_reg=1 → write_enb=000, fifo_full=0; then write_enb_reg=0 with addr=10 → write_enb=000.
- resetn low on cycle 25 of a timeout count → counter restarts, soft_reset deferred to 30 cycles after release.

Source files
------------

// File: rtl/router_sync.sv
// Router synchronizer: latches the header address, steers FIFO write enables and the
// full flag, and pulses a per-FIFO soft reset when an output port stops reading.

module router_sync_tmr #(
   parameter int TIMEOUT = 30
) (
   input  logic clock,
   input  logic resetn,
   input  logic vld,
   input  logic rd,
   output logic soft_reset
);
   logic [4:0] cnt;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt        <= '0;
         soft_reset <= 1'b0;
      end else if (!vld || rd) begin
         cnt        <= '0;
         soft_reset <= 1'b0;
      end else if (cnt == 5'(TIMEOUT - 1)) begin
         // wrap so the pulse repeats every TIMEOUT idle cycles
         cnt        <= '0;
         soft_reset <= 1'b1;
      end else begin
         cnt        <= cnt + 5'd1;
         soft_reset <= 1'b0;
      end
   end
endmodule

module router_sync #(
   parameter int TIMEOUT = 30
) (
   input  logic       detect_add,
   input  logic [1:0] data_in,
   input  logic       write_enb_reg,
   input  logic       clock,
   input  logic       resetn,
   input  logic       read_enb_0,
   input  logic       read_enb_1,
   input  logic       read_enb_2,
   input  logic       empty_0,
   input  logic       empty_1,
   input  logic       empty_2,
   input  logic       full_0,
   input  logic       full_1,
   input  logic       full_2,
   output logic       vld_out_0,
   output logic       vld_out_1,
   output logic       vld_out_2,
   output logic [2:0] write_enb,
   output logic       fifo_full,
   output logic       soft_reset_0,
   output logic       soft_reset_1,
   output logic       soft_reset_2
);
   localparam int NUM_LANES = 3;

   logic [1:0]           addr;
   logic [NUM_LANES-1:0] vld, rd, full, srst;

   assign vld  = ~{empty_2, empty_1, empty_0};
   assign rd   = {read_enb_2, read_enb_1, read_enb_0};
   assign full = {full_2, full_1, full_0};

   assign {vld_out_2, vld_out_1, vld_out_0}          = vld;
   assign {soft_reset_2, soft_reset_1, soft_reset_0} = srst;

   always_ff @(posedge clock) begin
      if (!resetn)         addr <= 2'b00;
      else if (detect_add) addr <= data_in;
   end

   // addr 11 is not a port: no write, never report full
   always_comb begin
      write_enb = '0;
      fifo_full = 1'b0;
      if (addr != 2'b11) begin
         write_enb[addr] = write_enb_reg;
         fifo_full       = full[addr];
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      router_sync_tmr #(.TIMEOUT(TIMEOUT)) u_tmr (
         .clock      (clock),
         .resetn     (resetn),
         .vld        (vld[i]),
         .rd         (rd[i]),
         .soft_reset (srst[i])
      );
   end
endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: stimulus pushes the expected outputs of each cycle,
// a monitor pops and compares them at the falling edge.

module tb_router_sync;
   logic       clock = 1'b1;
   logic       resetn, detect_add, write_enb_reg;
   logic [1:0] data_in;
   logic       read_enb_0, read_enb_1, read_enb_2;
   logic       empty_0, empty_1, empty_2;
   logic       full_0, full_1, full_2;
   logic       vld_out_0, vld_out_1, vld_out_2;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;

   typedef struct {
      string      name;
      int         k;
      logic [9:0] exp;
   } item_t;

   item_t q[$];
   int    n_vec = 0;
   int    n_err = 0;
   bit    done  = 1'b0;

   router_sync #(.TIMEOUT(30)) dut (
      .detect_add(detect_add), .data_in(data_in), .write_enb_reg(write_enb_reg),
      .clock(clock), .resetn(resetn),
      .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
      .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
      .full_0(full_0), .full_1(full_1), .full_2(full_2),
      .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
      .write_enb(write_enb), .fifo_full(fifo_full),
      .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
   );

   always #5 clock = ~clock;

   // Expected vector layout: {vld_out[2:0], write_enb[2:0], fifo_full, soft_reset[2:0]}
   task automatic vec(input string nm, input int k, input logic [2:0] vld,
                      input logic [2:0] we, input logic ff, input logic [2:0] sr);
      item_t it;
      it.name = nm;
      it.k    = k;
      it.exp  = {vld, we, ff, sr};
      q.push_back(it);
      @(posedge clock);
      #1;
   endtask

   initial begin : monitor
      item_t      it;
      logic [9:0] act;
      forever begin
         @(negedge clock);
         if (q.size() != 0) begin
            it  = q.pop_front();
            act = {vld_out_2, vld_out_1, vld_out_0, write_enb, fifo_full,
                   soft_reset_2, soft_reset_1, soft_reset_0};
            n_vec++;
            if (act !== it.exp) begin
               n_err++;
               $display("FAIL %s k=%0d: got vld=%b we=%b ff=%b sr=%b, want vld=%b we=%b ff=%b sr=%b",
                        it.name, it.k, act[9:7], act[6:4], act[3], act[2:0],
                        it.exp[9:7], it.exp[6:4], it.exp[3], it.exp[2:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      if (!done) begin
         $display("FAIL watchdog: bench did not complete in time");
         $fatal(1, "timeout");
      end
   end

   initial begin : stim
      logic [2:0] ewe;
      logic       eff;
      resetn = 1'b0; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
      {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
      {empty_2, empty_1, empty_0}          = 3'b011;
      {full_2, full_1, full_0}             = 3'b000;
      @(posedge clock);
      #1;

      // Phase A: address decode, then FIFO2 timeout while idle
      vec("rstA", 0, 3'b100, 3'b000, 1'b0, 3'b000);
      resetn = 1'b1;
      for (int k = 1; k <= 65; k++) begin
         ewe = 3'b000; eff = 1'b0;
         case (k)
            1: begin detect_add = 1; data_in = 2'b01; write_enb_reg = 1;
                     {full_2, full_1, full_0} = 3'b010; ewe = 3'b001; eff = 0; end
            2: begin detect_add = 0; ewe = 3'b010; eff = 1; end
            3: begin detect_add = 1; data_in = 2'b11; ewe = 3'b010; eff = 1; end
            4: begin detect_add = 0; {full_2, full_1, full_0} = 3'b111; ewe = 3'b000; eff = 0; end
            5: begin detect_add = 1; data_in = 2'b10; ewe = 3'b000; eff = 0; end
            6: begin detect_add = 0; write_enb_reg = 0; {full_2, full_1, full_0} = 3'b100;
                     ewe = 3'b000; eff = 1; end
            7: begin write_enb_reg = 1; ewe = 3'b100; eff = 1; end
            8: begin detect_add = 1; data_in = 2'b00; ewe = 3'b100; eff = 1; end
            9: begin detect_add = 0; {full_2, full_1, full_0} = 3'b101; ewe = 3'b001; eff = 1; end
            10: begin write_enb_reg = 0; {full_2, full_1, full_0} = 3'b000; end
            default: ;
         endcase
         vec("phaseA", k, 3'b100, ewe, eff, (k == 31 || k == 61) ? 3'b100 : 3'b000);
      end

      // Phase B: FIFO1 idle, a read on cycle 20 restarts the count
      resetn = 1'b0;
      {empty_2, empty_1, empty_0} = 3'b101;
      vec("rstB", 0, 3'b010, 3'b000, 1'b0, 3'b000);
      resetn = 1'b1;
      for (int k = 1; k <= 55; k++) begin
         read_enb_1 = (k == 20);
         vec("phaseB", k, 3'b010, 3'b000, 1'b0, (k == 51) ? 3'b010 : 3'b000);
      end
      read_enb_1 = 1'b0;

      // Phase C: FIFO0 idle, reset on cycle 25 defers the pulse
      resetn = 1'b0;
      {empty_2, empty_1, empty_0} = 3'b110;
      vec("rstC", 0, 3'b001, 3'b000, 1'b0, 3'b000);
      resetn = 1'b1;
      for (int k = 1; k <= 24; k++)
         vec("phaseC_pre", k, 3'b001, 3'b000, 1'b0, 3'b000);
      resetn = 1'b0;
      vec("phaseC_rst", 25, 3'b001, 3'b000, 1'b0, 3'b000);
      resetn = 1'b1;
      for (int k = 1; k <= 35; k++)
         vec("phaseC", k, 3'b001, 3'b000, 1'b0, (k == 31) ? 3'b001 : 3'b000);

      repeat (3) @(negedge clock);
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d vectors left unchecked, want 0", q.size());
      end
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
